watch_dp_gen: RTL and testbench

Parametrised clock-of-day datapath, successor to the fixed 100 Hz watch datapath. Contains an internal sub-second tick divider derived from the clock frequency, a single-cycle ripple-carry cascade (sub-second, second, minute, hour) and run/pause control. Also provides per-field up/down setting with optional carry, a parallel time load, and 12/24-hour display conversion. Sits between the button/mode control unit and the FND display formatter.

---
 rtl/watch_dp_gen.sv | 183 ++++++++++++++++++
 tb/tb_watch_dp_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/watch_dp_gen.sv
// watch_dp_gen: parametrised clock-of-day datapath.
// Contains a sub-second tick divider, a single-edge ripple cascade
// (sub/sec/min/hour), per-field up/down setting, parallel load and
// 12/24-hour display conversion.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   i_run              advance time when high; set/load still accepted when low
//   i_mode12           12-hour display select
//   i_up, i_down       single-cycle set step pulses
//   i_set_sec/min/hour field select for setting (priority sec > min > hour)
//   i_load, i_load_*   parallel time load (clamped to field max)
//   o_sub..o_hour      registered time fields (24 h)
//   o_disp_hour, o_pm  combinational display hour / PM flag
//   o_sec_tick         registered pulse after the sub counter wraps
//   o_day_tick         registered pulse after hour wraps 23->0 naturally
module watch_dp_gen #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SUB_HZ       = 100,
  parameter int unsigned INIT_HOUR    = 12,
  parameter int unsigned CARRY_ON_SET = 0,
  localparam int unsigned SUB_W       = (SUB_HZ > 1) ? $clog2(SUB_HZ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_mode12,
  input  logic             i_up,
  input  logic             i_down,
  input  logic             i_set_sec,
  input  logic             i_set_min,
  input  logic             i_set_hour,
  input  logic             i_load,
  input  logic [5:0]       i_load_sec,
  input  logic [5:0]       i_load_min,
  input  logic [4:0]       i_load_hour,
  output logic [SUB_W-1:0] o_sub,
  output logic [5:0]       o_sec,
  output logic [5:0]       o_min,
  output logic [4:0]       o_hour,
  output logic [4:0]       o_disp_hour,
  output logic             o_pm,
  output logic             o_sec_tick,
  output logic             o_day_tick
);

  localparam int unsigned DIV   = CLK_HZ / SUB_HZ;
  localparam int unsigned DIV_W = $clog2(DIV);

  logic [DIV_W-1:0] div_q;
  logic             sub_tick_c;

  logic             sub_wrap_c, sec_wrap_c, min_wrap_c, hour_wrap_c;
  logic [SUB_W-1:0] sub_nx_c;
  logic [5:0]       sec_nx_c, min_nx_c;
  logic [4:0]       hour_nx_c;

  logic [5:0]       sec_set_c, min_set_c;
  logic [4:0]       hour_set_c;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec60(input logic [5:0] v);
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v >= 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] dec24(input logic [4:0] v);
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  // Sub-second tick: last divider count while running
  assign sub_tick_c = i_run && (div_q == DIV_W'(DIV - 1));

  // Natural-count ripple: every field resolves on the same edge
  always_comb begin
    sub_wrap_c  = (o_sub == SUB_W'(SUB_HZ - 1));
    sec_wrap_c  = sub_wrap_c && (o_sec == 6'd59);
    min_wrap_c  = sec_wrap_c && (o_min == 6'd59);
    hour_wrap_c = min_wrap_c && (o_hour == 5'd23);
    sub_nx_c    = sub_wrap_c ? '0 : o_sub + SUB_W'(1);
    sec_nx_c    = sub_wrap_c ? inc60(o_sec) : o_sec;
    min_nx_c    = sec_wrap_c ? inc60(o_min) : o_min;
    hour_nx_c   = min_wrap_c ? inc24(o_hour) : o_hour;
  end

  // Set step: one field selected, optional carry/borrow stops at hour
  always_comb begin
    logic up_c, dn_c, min_up, min_dn, hour_up, hour_dn;
    sec_set_c  = o_sec;
    min_set_c  = o_min;
    hour_set_c = o_hour;
    up_c    = i_up && !i_down;
    dn_c    = i_down && !i_up;
    min_up  = 1'b0;
    min_dn  = 1'b0;
    hour_up = 1'b0;
    hour_dn = 1'b0;
    if (i_set_sec) begin
      if (up_c) begin
        sec_set_c = inc60(o_sec);
        min_up    = (CARRY_ON_SET != 0) && (o_sec == 6'd59);
      end else if (dn_c) begin
        sec_set_c = dec60(o_sec);
        min_dn    = (CARRY_ON_SET != 0) && (o_sec == 6'd0);
      end
    end else if (i_set_min) begin
      min_up = up_c;
      min_dn = dn_c;
    end else if (i_set_hour) begin
      hour_up = up_c;
      hour_dn = dn_c;
    end
    if (min_up) begin
      min_set_c = inc60(o_min);
      hour_up   = (CARRY_ON_SET != 0) && (o_min == 6'd59);
    end else if (min_dn) begin
      min_set_c = dec60(o_min);
      hour_dn   = (CARRY_ON_SET != 0) && (o_min == 6'd0);
    end
    if (hour_up) begin
      hour_set_c = inc24(o_hour);
    end else if (hour_dn) begin
      hour_set_c = dec24(o_hour);
    end
  end

  // State update: reset > load > sub-tick > set step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q      <= '0;
      o_sub      <= '0;
      o_sec      <= '0;
      o_min      <= '0;
      o_hour     <= 5'(INIT_HOUR);
      o_sec_tick <= 1'b0;
      o_day_tick <= 1'b0;
    end else if (i_load) begin
      div_q      <= '0;
      o_sub      <= '0;
      o_sec      <= (i_load_sec  > 6'd59) ? 6'd59 : i_load_sec;
      o_min      <= (i_load_min  > 6'd59) ? 6'd59 : i_load_min;
      o_hour     <= (i_load_hour > 5'd23) ? 5'd23 : i_load_hour;
      o_sec_tick <= 1'b0;
      o_day_tick <= 1'b0;
    end else if (sub_tick_c) begin
      div_q      <= '0;
      o_sub      <= sub_nx_c;
      o_sec      <= sec_nx_c;
      o_min      <= min_nx_c;
      o_hour     <= hour_nx_c;
      o_sec_tick <= sub_wrap_c;
      o_day_tick <= hour_wrap_c;
    end else begin
      if (i_run) begin
        div_q <= div_q + DIV_W'(1);
      end
      o_sec      <= sec_set_c;
      o_min      <= min_set_c;
      o_hour     <= hour_set_c;
      o_sec_tick <= 1'b0;
      o_day_tick <= 1'b0;
    end
  end

  // 12/24-hour display conversion, zero latency
  always_comb begin
    o_pm        = i_mode12 && (o_hour >= 5'd12);
    o_disp_hour = o_hour;
    if (i_mode12) begin
      if (o_hour == 5'd0) begin
        o_disp_hour = 5'd12;
      end else if (o_hour > 5'd12) begin
        o_disp_hour = o_hour - 5'd12;
      end
    end
  end

endmodule

// File: tb/tb_watch_dp_gen.sv
// Directed bench for watch_dp_gen: two instances (set-carry off / on)
// share all inputs; a vector table covers load/set/display, hand-written
// sequences cover timing, rollover, run/pause and reset.
module tb_watch_dp_gen;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned SUB_HZ = 10;
  localparam int unsigned SUB_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_run = 1'b0, i_mode12 = 1'b0, i_up = 1'b0, i_down = 1'b0;
  logic i_set_sec = 1'b0, i_set_min = 1'b0, i_set_hour = 1'b0, i_load = 1'b0;
  logic [5:0] i_load_sec = '0, i_load_min = '0;
  logic [4:0] i_load_hour = '0;

  logic [SUB_W-1:0] o0_sub, o1_sub;
  logic [5:0] o0_sec, o0_min, o1_sec, o1_min;
  logic [4:0] o0_hour, o0_disp_hour, o1_hour, o1_disp_hour;
  logic o0_pm, o0_sec_tick, o0_day_tick, o1_pm, o1_sec_tick, o1_day_tick;

  watch_dp_gen #(.CLK_HZ(CLK_HZ), .SUB_HZ(SUB_HZ), .INIT_HOUR(12), .CARRY_ON_SET(0)) u0 (
    .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_mode12(i_mode12),
    .i_up(i_up), .i_down(i_down), .i_set_sec(i_set_sec), .i_set_min(i_set_min),
    .i_set_hour(i_set_hour), .i_load(i_load), .i_load_sec(i_load_sec),
    .i_load_min(i_load_min), .i_load_hour(i_load_hour),
    .o_sub(o0_sub), .o_sec(o0_sec), .o_min(o0_min), .o_hour(o0_hour),
    .o_disp_hour(o0_disp_hour), .o_pm(o0_pm),
    .o_sec_tick(o0_sec_tick), .o_day_tick(o0_day_tick));

  watch_dp_gen #(.CLK_HZ(CLK_HZ), .SUB_HZ(SUB_HZ), .INIT_HOUR(12), .CARRY_ON_SET(1)) u1 (
    .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_mode12(i_mode12),
    .i_up(i_up), .i_down(i_down), .i_set_sec(i_set_sec), .i_set_min(i_set_min),
    .i_set_hour(i_set_hour), .i_load(i_load), .i_load_sec(i_load_sec),
    .i_load_min(i_load_min), .i_load_hour(i_load_hour),
    .o_sub(o1_sub), .o_sec(o1_sec), .o_min(o1_min), .o_hour(o1_hour),
    .o_disp_hour(o1_disp_hour), .o_pm(o1_pm),
    .o_sec_tick(o1_sec_tick), .o_day_tick(o1_day_tick));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int lh, lm, ls;
    int m12, ss, sm, sh, up, dn;
    int eh0, em0, es0;
    int eh1, em1, es1;
    int edisp, epm;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    i_load_hour = 5'(h);
    i_load_min  = 6'(m);
    i_load_sec  = 6'(s);
    i_load = 1'b1;
    step(1);
    i_load = 1'b0;
  endtask

  initial begin
    //           lh  lm  ls m12 ss sm sh up dn  eh0 em0 es0  eh1 em1 es1 disp pm
    vecs[0]  = '{10, 59, 59, 0, 1, 0, 0, 1, 0,  10, 59,  0,  11,  0,  0,  10, 0};
    vecs[1]  = '{ 0,  0, 30, 0, 0, 1, 0, 0, 1,   0, 59, 30,  23, 59, 30,   0, 0};
    vecs[2]  = '{ 0,  0,  0, 1, 0, 0, 0, 0, 0,   0,  0,  0,   0,  0,  0,  12, 0};
    vecs[3]  = '{11,  0,  0, 1, 0, 0, 0, 0, 0,  11,  0,  0,  11,  0,  0,  11, 0};
    vecs[4]  = '{12,  0,  0, 1, 0, 0, 0, 0, 0,  12,  0,  0,  12,  0,  0,  12, 1};
    vecs[5]  = '{13,  0,  0, 1, 0, 0, 0, 0, 0,  13,  0,  0,  13,  0,  0,   1, 1};
    vecs[6]  = '{23,  0,  0, 1, 0, 0, 0, 0, 0,  23,  0,  0,  23,  0,  0,  11, 1};
    vecs[7]  = '{13,  0,  0, 0, 0, 0, 0, 0, 0,  13,  0,  0,  13,  0,  0,  13, 0};
    vecs[8]  = '{ 5, 10, 20, 0, 1, 0, 1, 1, 0,   5, 10, 21,   5, 10, 21,   5, 0};
    vecs[9]  = '{ 5, 10, 20, 0, 1, 0, 0, 1, 1,   5, 10, 20,   5, 10, 20,   5, 0};
    vecs[10] = '{30, 10, 61, 0, 0, 0, 0, 0, 0,  23, 10, 59,  23, 10, 59,  23, 0};
    vecs[11] = '{ 5, 10,  0, 0, 1, 0, 0, 0, 1,   5, 10, 59,   5,  9, 59,   5, 0};
    vecs[12] = '{23,  0,  0, 0, 0, 0, 1, 1, 0,   0,  0,  0,   0,  0,  0,   0, 0};
    vecs[13] = '{ 3, 59, 10, 0, 0, 1, 0, 1, 0,   3,  0, 10,   4,  0, 10,   3, 0};
    vecs[14] = '{ 2, 62,  5, 1, 0, 0, 0, 0, 0,   2, 59,  5,   2, 59,  5,   2, 0};
    vecs[15] = '{ 0,  0,  0, 1, 1, 0, 0, 0, 1,   0,  0, 59,  23, 59, 59,  12, 0};

    // Reset values, first sub increment, first second
    rst_n = 1'b0;
    i_run = 1'b1;
    step(1);
    chk("rst hour0", int'(o0_hour), 12);
    chk("rst hour1", int'(o1_hour), 12);
    chk("rst sub", int'(o0_sub), 0);
    chk("rst sec", int'(o0_sec), 0);
    chk("rst min", int'(o0_min), 0);
    chk("rst sec_tick", int'(o0_sec_tick), 0);
    rst_n = 1'b1;
    step(99);
    chk("sub before 100 clk", int'(o0_sub), 0);
    step(1);
    chk("sub at 100 clk", int'(o0_sub), 1);
    step(899);
    chk("sec at 999 clk", int'(o0_sec), 0);
    chk("sub at 999 clk", int'(o0_sub), 9);
    chk("sec_tick at 999 clk", int'(o0_sec_tick), 0);
    step(1);
    chk("sec at 1000 clk", int'(o0_sec), 1);
    chk("sub at 1000 clk", int'(o0_sub), 0);
    chk("sec_tick at 1000 clk", int'(o0_sec_tick), 1);
    step(1);
    chk("sec_tick after pulse", int'(o0_sec_tick), 0);

    // Midnight rollover in one edge
    do_load(23, 59, 59);
    chk("load hour", int'(o0_hour), 23);
    chk("load sub clear", int'(o0_sub), 0);
    chk("load no tick", int'(o0_sec_tick), 0);
    step(999);
    chk("pre-midnight sub", int'(o0_sub), 9);
    chk("pre-midnight sec", int'(o0_sec), 59);
    chk("pre-midnight day_tick", int'(o0_day_tick), 0);
    step(1);
    chk("midnight hour", int'(o0_hour), 0);
    chk("midnight min", int'(o0_min), 0);
    chk("midnight sec", int'(o0_sec), 0);
    chk("midnight sub", int'(o0_sub), 0);
    chk("midnight day_tick", int'(o0_day_tick), 1);
    chk("midnight sec_tick", int'(o0_sec_tick), 1);
    chk("midnight hour carry inst", int'(o1_hour), 0);
    step(1);
    chk("day_tick one cycle", int'(o0_day_tick), 0);

    // Load / set / display table, time paused
    i_run = 1'b0;
    for (int i = 0; i < 16; i++) begin
      i_mode12 = 1'(vecs[i].m12);
      do_load(vecs[i].lh, vecs[i].lm, vecs[i].ls);
      i_set_sec  = 1'(vecs[i].ss);
      i_set_min  = 1'(vecs[i].sm);
      i_set_hour = 1'(vecs[i].sh);
      i_up       = 1'(vecs[i].up);
      i_down     = 1'(vecs[i].dn);
      step(1);
      i_set_sec = 1'b0; i_set_min = 1'b0; i_set_hour = 1'b0;
      i_up = 1'b0; i_down = 1'b0;
      chk($sformatf("v%0d hour c0", i), int'(o0_hour), vecs[i].eh0);
      chk($sformatf("v%0d min c0", i), int'(o0_min), vecs[i].em0);
      chk($sformatf("v%0d sec c0", i), int'(o0_sec), vecs[i].es0);
      chk($sformatf("v%0d hour c1", i), int'(o1_hour), vecs[i].eh1);
      chk($sformatf("v%0d min c1", i), int'(o1_min), vecs[i].em1);
      chk($sformatf("v%0d sec c1", i), int'(o1_sec), vecs[i].es1);
      chk($sformatf("v%0d disp_hour", i), int'(o0_disp_hour), vecs[i].edisp);
      chk($sformatf("v%0d pm", i), int'(o0_pm), vecs[i].epm);
      chk($sformatf("v%0d sub", i), int'(o0_sub), 0);
      chk($sformatf("v%0d sec_tick", i), int'(o0_sec_tick), 0);
    end
    i_mode12 = 1'b0;

    // Set pulse coinciding with a sub-tick is dropped
    i_run = 1'b1;
    do_load(1, 2, 3);
    step(99);
    i_set_sec = 1'b1; i_up = 1'b1;
    step(1);
    i_set_sec = 1'b0; i_up = 1'b0;
    chk("coincident sub", int'(o0_sub), 1);
    chk("coincident sec", int'(o0_sec), 3);
    i_set_sec = 1'b1; i_up = 1'b1;
    step(1);
    i_set_sec = 1'b0; i_up = 1'b0;
    chk("lone step sec", int'(o0_sec), 4);
    chk("lone step sub", int'(o0_sub), 1);

    // Pause holds state and divider phase
    do_load(1, 2, 3);
    step(250);
    chk("pre-pause sub", int'(o0_sub), 2);
    i_run = 1'b0;
    begin
      int bad = 0;
      for (int c = 0; c < 500; c++) begin
        step(1);
        if (o0_sec_tick || o0_day_tick || o0_sub != 4'd2 || o0_sec != 6'd3) bad++;
      end
      chk("pause frozen cycles bad", bad, 0);
    end
    i_run = 1'b1;
    step(49);
    chk("resume sub hold phase", int'(o0_sub), 2);
    step(1);
    chk("resume sub step", int'(o0_sub), 3);

    // Reset mid-count
    step(30);
    rst_n = 1'b0;
    step(1);
    chk("midrst hour", int'(o0_hour), 12);
    chk("midrst sec", int'(o0_sec), 0);
    chk("midrst min", int'(o0_min), 0);
    chk("midrst sub", int'(o0_sub), 0);
    chk("midrst hour c1", int'(o1_hour), 12);
    rst_n = 1'b1;
    step(99);
    chk("midrst phase sub 99", int'(o0_sub), 0);
    step(1);
    chk("midrst phase sub 100", int'(o0_sub), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
